// File: rtl/serial_sub_restore_nbit_if.sv
// Handshake and operand bus for the bit-serial minuend rebuilder.
// The master drives the request and operands; the slave returns the result and status.
interface serial_sub_restore_nbit_if #(
    parameter int NUM_BIT = 8
);
    logic               start_i;
    logic [NUM_BIT-1:0] mag_i;
    logic               neg_i;
    logic [NUM_BIT-1:0] b_i;
    logic [NUM_BIT-1:0] a_o;
    logic               ovf_o;
    logic               busy_o;
    logic               done_o;

    modport master (
        output start_i, mag_i, neg_i, b_i,
        input  a_o, ovf_o, busy_o, done_o
    );

    modport slave (
        input  start_i, mag_i, neg_i, b_i,
        output a_o, ovf_o, busy_o, done_o
    );
endinterface

// File: rtl/serial_sub_restore_nbit.sv
// Bit-serial rebuild of the minuend a = b +/- mag from a sign-magnitude difference.
// One full-adder slice processes one bit per clock, LSB first, behind a start/busy/done handshake.
module serial_sub_restore_nbit #(
    parameter int NUM_BIT = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    serial_sub_restore_nbit_if.slave        bus
);
    localparam int CW = $clog2(NUM_BIT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_BIT-1:0] opa_q, opa_d;
    logic [NUM_BIT-1:0] opb_q, opb_d;
    logic [NUM_BIT-1:0] res_q, res_d;
    logic [NUM_BIT-1:0] a_q, a_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               c_q, c_d;
    logic               neg_q, neg_d;
    logic               ovf_q, ovf_d;

    logic               sum_bit;
    logic               carry_nxt;

    // Single full-adder slice on the current LSBs.
    assign sum_bit   = opa_q[0] ^ opb_q[0] ^ c_q;
    assign carry_nxt = (opa_q[0] & opb_q[0]) | (opa_q[0] & c_q) | (opb_q[0] & c_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            a_q     <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            a_q     <= a_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            neg_q   <= neg_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        res_d   = res_q;
        a_d     = a_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        neg_d   = neg_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    // Subtraction as b + ~mag + 1: the +1 enters as the initial carry.
                    opa_d   = bus.b_i;
                    opb_d   = bus.neg_i ? ~bus.mag_i : bus.mag_i;
                    c_d     = bus.neg_i;
                    neg_d   = bus.neg_i;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                c_d   = carry_nxt;
                res_d = {sum_bit, res_q[NUM_BIT-1:1]};
                opa_d = {1'b0, opa_q[NUM_BIT-1:1]};
                opb_d = {1'b0, opb_q[NUM_BIT-1:1]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(NUM_BIT - 1)) begin
                    // Final carry means no borrow on the subtract path, hence the inversion.
                    a_d     = {sum_bit, res_q[NUM_BIT-1:1]};
                    ovf_d   = neg_q ? ~carry_nxt : carry_nxt;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.a_o    = a_q;
    assign bus.ovf_o  = ovf_q;
    assign bus.busy_o = (state_q == RUN);
    assign bus.done_o = (state_q == DONE);
endmodule

// File: tb/tb_serial_sub_restore_nbit.sv
// Directed and randomised checks of the bit-serial minuend rebuilder at NUM_BIT=8.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_serial_sub_restore_nbit;
    localparam int N = 8;

    logic clk;
    logic rst_n;

    int unsigned n_total;
    int unsigned n_bad;

    serial_sub_restore_nbit_if #(.NUM_BIT(N)) bus ();

    serial_sub_restore_nbit #(.NUM_BIT(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d want=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Launches one op from just after an edge and follows it through RUN and DONE.
    // disturb: re-pulse start in RUN cycle 3 and in DONE, and scramble the operands.
    task automatic run_op(input logic [N-1:0] m, input logic ng, input logic [N-1:0] bb,
                          input logic [N-1:0] exp_a, input logic exp_ovf,
                          input bit disturb, input string tag);
        bus.start_i = 1'b1;
        bus.mag_i   = m;
        bus.neg_i   = ng;
        bus.b_i     = bb;
        step();
        bus.start_i = 1'b0;
        for (int i = 1; i <= N; i++) begin
            check({tag, " busy"}, {31'd0, bus.busy_o}, 32'd1);
            check({tag, " done-early"}, {31'd0, bus.done_o}, 32'd0);
            if (disturb) begin
                bus.mag_i   = 8'hA5 ^ N'(i);
                bus.b_i     = 8'h3C + N'(i);
                bus.neg_i   = ~ng;
                bus.start_i = (i == 3);
            end
            step();
        end
        bus.start_i = 1'b0;
        check({tag, " done"}, {31'd0, bus.done_o}, 32'd1);
        check({tag, " busy-in-done"}, {31'd0, bus.busy_o}, 32'd0);
        check({tag, " a"}, {24'd0, bus.a_o}, {24'd0, exp_a});
        check({tag, " ovf"}, {31'd0, bus.ovf_o}, {31'd0, exp_ovf});
        if (disturb) bus.start_i = 1'b1;
        step();
        bus.start_i = 1'b0;
        check({tag, " done-gone"}, {31'd0, bus.done_o}, 32'd0);
        check({tag, " idle"}, {31'd0, bus.busy_o}, 32'd0);
        check({tag, " a-held"}, {24'd0, bus.a_o}, {24'd0, exp_a});
        if (disturb) begin
            step();
            check({tag, " no-requeue"}, {31'd0, bus.busy_o}, 32'd0);
        end
    endtask

    initial begin
        logic [N-1:0] rm;
        logic [N-1:0] rb;
        logic         rn;
        logic [N:0]   full;
        logic         eovf;
        int unsigned  done_seen;

        n_total     = 0;
        n_bad       = 0;
        rst_n       = 1'b0;
        bus.start_i = 1'b0;
        bus.mag_i   = '0;
        bus.neg_i   = 1'b0;
        bus.b_i     = '0;
        repeat (3) step();
        check("reset busy", {31'd0, bus.busy_o}, 32'd0);
        check("reset done", {31'd0, bus.done_o}, 32'd0);
        check("reset a", {24'd0, bus.a_o}, 32'd0);
        check("reset ovf", {31'd0, bus.ovf_o}, 32'd0);
        rst_n = 1'b1;
        step();

        run_op(8'd3,   1'b1, 8'd9,   8'd6,   1'b0, 1'b0, "t1 9-3");
        run_op(8'd6,   1'b1, 8'd10,  8'd4,   1'b0, 1'b0, "t2 10-6");
        run_op(8'd200, 1'b0, 8'd100, 8'd44,  1'b1, 1'b0, "t2 100+200");
        run_op(8'd5,   1'b1, 8'd3,   8'd254, 1'b1, 1'b0, "t3 3-5");
        run_op(8'd0,   1'b1, 8'd0,   8'd0,   1'b0, 1'b0, "t3 0-0");
        run_op(8'd0,   1'b1, 8'd77,  8'd77,  1'b0, 1'b0, "t3 77-0");
        run_op(8'd255, 1'b0, 8'd1,   8'd0,   1'b1, 1'b0, "t3 1+255");
        run_op(8'd20,  1'b0, 8'd30,  8'd50,  1'b0, 1'b1, "t4 disturb");

        // Abort in RUN cycle 4; a previous result (50) is held before reset.
        bus.start_i = 1'b1;
        bus.mag_i   = 8'd7;
        bus.neg_i   = 1'b0;
        bus.b_i     = 8'd9;
        step();
        bus.start_i = 1'b0;
        repeat (3) step();
        check("t5 busy-before-rst", {31'd0, bus.busy_o}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("t5 rst busy", {31'd0, bus.busy_o}, 32'd0);
        check("t5 rst done", {31'd0, bus.done_o}, 32'd0);
        check("t5 rst a", {24'd0, bus.a_o}, 32'd0);
        check("t5 rst ovf", {31'd0, bus.ovf_o}, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus.done_o || bus.busy_o) done_seen++;
        end
        check("t5 no-done-after-rst", done_seen, 32'd0);
        run_op(8'd1, 1'b0, 8'd255, 8'd0, 1'b1, 1'b0, "t5 255+1");

        // Back-to-back sweep: run_op returns in IDLE, so each next start lands 10 cycles later.
        for (int k = 0; k < 200; k++) begin
            rm = N'($urandom);
            rb = N'($urandom);
            rn = 1'($urandom);
            if (rn) begin
                full = {1'b0, rb} - {1'b0, rm};
                eovf = (rm > rb);
            end else begin
                full = {1'b0, rb} + {1'b0, rm};
                eovf = full[N];
            end
            run_op(rm, rn, rb, full[N-1:0], eovf, 1'b0, "t6 sweep");
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
